decode_stage_pipe: RTL
======================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, meaning datapath, pc, imm and target width.
REQ-002 The module SHALL take parameter REG_IDX_W, default 3, meaning register index width (8 GPRs).
REQ-003 The module SHALL take parameter WIN_BYTES, default 5 (minimum 5), meaning instruction window width in bytes; opcode is in the most-significant byte.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  fetch presents an instruction window.
REQ-007 in_ready  output  1  decode accepts the window this cycle.
REQ-008 in_pc  input  DATA_W  address of the opcode byte.
REQ-009 in_instr  input  8*WIN_BYTES  instruction bytes; byte0 = [8*WIN_BYTES-1 -: 8].
REQ-010 flush  input  1  discard the held output entry (redirect from later stage).
REQ-011 out_valid  output  1  decoded entry held.
REQ-012 out_ready  input  1  downstream accepts the entry.
REQ-013 out_pc, out_imm, out_next_pc, out_target  output  DATA_W each  pc, immediate, pc+length, next_pc+imm.
REQ-014 out_src1_idx, out_src2_idx  output  REG_IDX_W each  dst/src1 and src2 register indices.
REQ-015 out_ctrl  output  7  {src2mux, op, read1, read2, we, is_jmp, is_halt}.
REQ-016 out_length  output  4  instruction length in bytes.
REQ-017 out_illegal  output  1  opcode not in the decode table.
REQ-018 halted  output  1  HLT has been accepted.

Function
REQ-019 Decode table SHALL be: 01 ADD r/m,r (len 2, src1=modrm[2:0], src2=modrm[5:3], op/read1/read2/we=1); 05 ADD EAX,imm32 (len 5, src1=0, op/read2/we/src2mux=1); 83 /0 ADD r/m,sext imm8 (len 3); B8-BF MOV r,imm32 (len 5, src1=opcode[2:0], read2/we/src2mux=1); E9 JMP rel32 (len 5); EB JMP sext rel8 (len 2); 90 NOP (len 1, all ctrl 0); F4 HLT (len 1, is_halt=1).
REQ-020 imm32 SHALL be assembled little-endian from bytes 1..4; imm8 from byte 2 (83) or byte 1 (EB), sign-extended to DATA_W.
REQ-021 Any other opcode, or 83 with modrm[5:3]!=0, SHALL give out_illegal=1, ctrl=0, length=1, we=0.
REQ-022 out_next_pc SHALL be in_pc+length and out_target next_pc+imm, both modulo 2^DATA_W.
REQ-023 Decode SHALL be registered: window accepted in cycle N appears on outputs with out_valid=1 in cycle N+1 (latency 1).
REQ-024 in_ready SHALL equal !halted && (!out_valid || out_ready); acceptance = in_valid && in_ready.
REQ-025 Output fields SHALL stay stable while out_valid && !out_ready.
REQ-026 Simultaneous pop and accept SHALL replace the entry with no bubble.
REQ-027 flush SHALL clear out_valid next cycle and block acceptance that cycle (in_ready forced 0); flush overrides out_ready.
REQ-028 FSM states RUN and HALT: RUN->HALT when an F4 window is accepted; HALT is left only by reset; halted=1 in HALT.
REQ-029 The HLT entry SHALL itself be delivered downstream; in HALT in_ready=0 and no further windows are accepted.
REQ-030 flush in the HLT-acceptance cycle SHALL discard the accept; state remains RUN.

Reset
REQ-031 On rst_n=0, asynchronously: out_valid=0, halted=0, state RUN, all output data fields 0.
REQ-032 Reset mid-stall SHALL drop the held entry; the first accept after release produces out_valid one cycle later.

Verification
REQ-033 in_pc=0x100, window 05 78 56 34 12 -> next cycle out_imm=0x12345678, src1=0, ctrl=7'b1101100, length=5, next_pc=0x105.
REQ-034 in_pc=0x200, window EB FE -> is_jmp=1, imm=0xFFFFFFFE, next_pc=0x202, target=0x200.
REQ-035 Back-to-back BB/01 D8 with out_ready held 0 for 3 cycles -> in_ready=0, outputs stable at MOV EBX; release -> ADD entry follows with no bubble.
REQ-036 Window F4 then 90 -> HLT delivered, halted=1, in_ready stays 0, NOP never appears; rst_n pulse -> halted=0.
REQ-037 Opcode 0F, and 83 with modrm=0x28 -> out_illegal=1, we=0, length=1.
REQ-038 flush asserted with out_valid=1, out_ready=0 -> out_valid=0 next cycle; concurrent in_valid window not accepted.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Single-entry registered decode stage for a small x86-like subset.
// Decodes the fetch window combinationally and holds one result behind a valid/ready output.
module decode_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 3,
  parameter int WIN_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_pc,
  input  logic [8*WIN_BYTES-1:0] in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_imm,
  output logic [DATA_W-1:0]      out_next_pc,
  output logic [DATA_W-1:0]      out_target,
  output logic [REG_IDX_W-1:0]   out_src1_idx,
  output logic [REG_IDX_W-1:0]   out_src2_idx,
  output logic [6:0]             out_ctrl,
  output logic [3:0]             out_length,
  output logic                   out_illegal,
  output logic                   halted
);

  // Handshake: a window transfers when in_valid && in_ready; an entry leaves when
  // out_valid && out_ready && !flush. flush drops the held entry without delivering it.

  // ctrl = {src2mux, op, read1, read2, we, is_jmp, is_halt}
  localparam logic [6:0] CTRL_ADD_RR  = 7'b0111100;
  localparam logic [6:0] CTRL_ADD_IMM = 7'b1101100;
  localparam logic [6:0] CTRL_MOV_IMM = 7'b1001100;
  localparam logic [6:0] CTRL_JMP     = 7'b0000010;
  localparam logic [6:0] CTRL_HLT     = 7'b0000001;
  localparam int TOP = 8*WIN_BYTES-1;

  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;

  logic [7:0] b0, b1, b2, b3, b4;
  assign b0 = in_instr[TOP    -: 8];
  assign b1 = in_instr[TOP-8  -: 8];
  assign b2 = in_instr[TOP-16 -: 8];
  assign b3 = in_instr[TOP-24 -: 8];
  assign b4 = in_instr[TOP-32 -: 8];

  logic [DATA_W-1:0] imm32_w, sext_b1, sext_b2;
  assign imm32_w = DATA_W'($signed({b4, b3, b2, b1}));
  assign sext_b1 = DATA_W'($signed(b1));
  assign sext_b2 = DATA_W'($signed(b2));

  logic [DATA_W-1:0]    d_imm, d_next_pc, d_target;
  logic [REG_IDX_W-1:0] d_src1, d_src2;
  logic [6:0]           d_ctrl;
  logic [3:0]           d_len;
  logic                 d_illegal;

  always_comb begin
    d_imm     = '0;
    d_src1    = '0;
    d_src2    = '0;
    d_ctrl    = '0;
    d_len     = 4'd1;
    d_illegal = 1'b0;
    case (b0) inside
      8'h01: begin
        d_len  = 4'd2;
        d_src1 = REG_IDX_W'(b1[2:0]);
        d_src2 = REG_IDX_W'(b1[5:3]);
        d_ctrl = CTRL_ADD_RR;
      end
      8'h05: begin
        d_len  = 4'd5;
        d_imm  = imm32_w;
        d_ctrl = CTRL_ADD_IMM;
      end
      8'h83: begin
        // Only the /0 (ADD) extension of group 1 is implemented.
        if (b1[5:3] == 3'd0) begin
          d_len  = 4'd3;
          d_src1 = REG_IDX_W'(b1[2:0]);
          d_imm  = sext_b2;
          d_ctrl = CTRL_ADD_IMM;
        end else begin
          d_illegal = 1'b1;
        end
      end
      [8'hB8:8'hBF]: begin
        d_len  = 4'd5;
        d_src1 = REG_IDX_W'(b0[2:0]);
        d_imm  = imm32_w;
        d_ctrl = CTRL_MOV_IMM;
      end
      8'hE9: begin
        d_len  = 4'd5;
        d_imm  = imm32_w;
        d_ctrl = CTRL_JMP;
      end
      8'hEB: begin
        d_len  = 4'd2;
        d_imm  = sext_b1;
        d_ctrl = CTRL_JMP;
      end
      8'h90: d_len = 4'd1;
      8'hF4: d_ctrl = CTRL_HLT;
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_next_pc = in_pc + DATA_W'(d_len);
  assign d_target  = d_next_pc + d_imm;

  logic accept;
  assign halted   = (state_q == HALT);
  assign in_ready = !halted && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && b0 == 8'hF4) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_next_pc  <= '0;
      out_target   <= '0;
      out_src1_idx <= '0;
      out_src2_idx <= '0;
      out_ctrl     <= '0;
      out_length   <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= d_imm;
      out_next_pc  <= d_next_pc;
      out_target   <= d_target;
      out_src1_idx <= d_src1;
      out_src2_idx <= d_src2;
      out_ctrl     <= d_ctrl;
      out_length   <= d_len;
      out_illegal  <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
